div_ctrl: RTL
=============

// Module: div_ctrl
// PURPOSE
//   Issue/retire controller for the iterative divider (div). Accepts RV32M DIV/DIVU/REM/REMU
//   requests over a valid/ready handshake and resolves RISC-V special cases locally.
//   Reuses the last quotient/remainder pair so a DIV+REM on the same operands issues once.
//   Drives div's enable/is_signed/src/sink, waits for completed and returns quo or res.
// PARAMETERS
//   WIDTH     32   operand/result width
//   TAG_W     5    width of request tag (destination register index)
//   CACHE_EN  1    1 = enable last-result reuse; 0 = every normal request issues to div
// PORTS
//   clk            in   1        clock, rising edge
//   rst            in   1        asynchronous, active-high reset
//   req_valid      in   1        request present
//   req_ready      out  1        controller can accept (IDLE only)
//   req_op         in   2        00 DIV, 01 DIVU, 10 REM, 11 REMU (= funct3[1:0])
//   req_a          in   WIDTH    dividend
//   req_b          in   WIDTH    divisor
//   req_tag        in   TAG_W    returned unchanged with the response
//   resp_valid     out  1        result present; held until resp_ready
//   resp_ready     in   1        consumer accepts result
//   resp_data      out  WIDTH    quotient (DIV/DIVU) or remainder (REM/REMU)
//   resp_tag       out  TAG_W    tag of the request being answered
//   div_enable     out  1        one-cycle start pulse to div
//   div_is_signed  out  1        1 for DIV/REM
//   div_src        out  WIDTH    dividend to div; stable from issue until completed
//   div_sink       out  WIDTH    divisor to div; stable from issue until completed
//   div_completed  in   1        div result valid
//   div_quo        in   WIDTH    div quotient
//   div_res        in   WIDTH    div remainder
// BEHAVIOUR
//   Reset: state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_tag=0; div_enable=0;
//     div_is_signed=0; div_src=div_sink=0; cache invalid.
//   FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Accept = req_valid & req_ready in IDLE.
//     Operands, op and tag are latched on accept.
//   Accept classification, in priority order:
//     1) b==0: quo=all ones, rem=a -> RESP.
//     2) signed op, a==0x8000_0000, b==all ones: quo=0x8000_0000, rem=0 -> RESP.
//     3) CACHE_EN, cache valid, a/b/signedness match cached -> RESP using cached pair.
//     4) otherwise -> ISSUE.
//   ISSUE (1 cycle): div_enable=1; div_src/div_sink/div_is_signed driven from latches -> WAIT.
//   WAIT: div_completed ignored in the ISSUE cycle. First cycle with div_completed=1: capture
//     quo/res, load cache (a,b,signed,quo,res), cache valid=1 -> RESP.
//   RESP: resp_valid=1; resp_data = op[1] ? rem : quo. resp_valid=1 & resp_ready=1 -> IDLE.
//     No request accepted in RESP.
//   Latency: special case or cache hit: accept at T, resp_valid at T+1.
//     Normal: accept T, div_enable at T+1, completed seen at C (C>=T+2), resp_valid at C+1.
//   Cache: special cases never load or invalidate it. CACHE_EN=0: cache valid stays 0.
//   Back-pressure: resp_data/resp_tag stable while resp_valid=1 & resp_ready=0.
//   div_enable is never asserted outside ISSUE. At most one division is in flight.
//   Reset mid-operation (any state): immediate return to reset values. Any pending result is
//     dropped. div shares rst.
// TESTING
//   DIVU a=100 b=7 -> one div_enable pulse; resp_data=14 one cycle after div_completed.
//   Then REMU a=100 b=7 -> no div_enable; resp_data=2 at accept+1 (cache hit).
//   Cache miss on signedness: REM a=-7 b=2 after DIVU a=-7 b=2 -> issues; resp_data=0xFFFF_FFFF.
//   DIV a=5 b=0 -> resp_data=0xFFFF_FFFF; REM a=5 b=0 -> 5; neither pulses div_enable.
//   DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM of same -> 0; no div_enable.
//   Back-pressure: resp_ready=0 for 5 cycles -> resp_valid, resp_data and resp_tag held;
//     req_ready=0 until handshake.
//   rst pulsed in WAIT -> all outputs at reset values; next request with CACHE_EN=1 issues to div.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: issue/retire controller in front of the iterative divider.
// Accepts RV32M DIV/DIVU/REM/REMU requests, answers RISC-V special cases
// and repeated operand pairs locally, and otherwise runs one division on div.
//
// Handshake rules (both request and response channels):
//   a transfer happens on a rising edge where valid=1 and ready=1; a producer
//   holds valid and its payload stable until that edge; ready may depend on
//   state only (never combinationally on valid).
module div_ctrl #(
    parameter int WIDTH    = 32,
    parameter int TAG_W    = 5,
    parameter int CACHE_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    // request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    // response channel
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag,
    // divider side
    output logic             div_enable,
    output logic             div_is_signed,
    output logic [WIDTH-1:0] div_src,
    output logic [WIDTH-1:0] div_sink,
    input  logic             div_completed,
    input  logic [WIDTH-1:0] div_quo,
    input  logic [WIDTH-1:0] div_res,
    // debug view of the controller state
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam bit              USE_CACHE = (CACHE_EN != 0);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state;
    state_t state_next;

    // Latched request fields (operands also feed the divider directly)
    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] sink_q;
    logic             signed_q;
    logic             want_rem_q;

    // Last divider result and the operands that produced it
    logic             cache_valid;
    logic [WIDTH-1:0] cache_a;
    logic [WIDTH-1:0] cache_b;
    logic             cache_signed;
    logic [WIDTH-1:0] cache_quo;
    logic [WIDTH-1:0] cache_rem;

    // Request classification, evaluated on the incoming operands
    logic             accept;
    logic             req_signed;
    logic             div_by_zero;
    logic             overflow;
    logic             cache_hit;
    logic             resolve_local;
    logic [WIDTH-1:0] local_quo;
    logic [WIDTH-1:0] local_rem;
    logic [WIDTH-1:0] local_data;
    logic [WIDTH-1:0] done_data;

    assign accept      = (state == S_IDLE) && req_valid;
    assign req_signed  = ~req_op[0];
    assign div_by_zero = (req_b == '0);
    assign overflow    = req_signed && (req_a == MIN_NEG) && (req_b == ALL_ONES);
    assign cache_hit   = USE_CACHE && cache_valid && (cache_a == req_a) &&
                         (cache_b == req_b) && (cache_signed == req_signed);
    assign resolve_local = div_by_zero || overflow || cache_hit;

    // Result for locally resolved requests; zero-divisor wins over overflow,
    // which wins over a cache hit
    always_comb begin
        local_quo = cache_quo;
        local_rem = cache_rem;
        if (div_by_zero) begin
            local_quo = ALL_ONES;
            local_rem = req_a;
        end else if (overflow) begin
            local_quo = MIN_NEG;
            local_rem = '0;
        end
    end

    assign local_data = req_op[1] ? local_rem : local_quo;
    assign done_data  = want_rem_q ? div_res : div_quo;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; div_completed is only looked at once in WAIT
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = resolve_local ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (div_completed) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake and divider strobes are pure functions of the state
    assign req_ready     = (state == S_IDLE);
    assign resp_valid    = (state == S_RESP);
    assign div_enable    = (state == S_ISSUE);
    assign div_is_signed = signed_q;
    assign div_src       = src_q;
    assign div_sink      = sink_q;
    assign state_dbg     = state;

    // Request latches and response register; operands only change on accept,
    // so div_src/div_sink stay put for the whole division
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q      <= '0;
            sink_q     <= '0;
            signed_q   <= 1'b0;
            want_rem_q <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
        end else if (accept) begin
            src_q      <= req_a;
            sink_q     <= req_b;
            signed_q   <= req_signed;
            want_rem_q <= req_op[1];
            resp_tag   <= req_tag;
            if (resolve_local) begin
                resp_data <= local_data;
            end
        end else if ((state == S_WAIT) && div_completed) begin
            resp_data <= done_data;
        end
    end

    // Result cache: loaded only by a real division, never by special cases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid  <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_signed <= 1'b0;
            cache_quo    <= '0;
            cache_rem    <= '0;
        end else if (USE_CACHE && (state == S_WAIT) && div_completed) begin
            cache_valid  <= 1'b1;
            cache_a      <= src_q;
            cache_b      <= sink_q;
            cache_signed <= signed_q;
            cache_quo    <= div_quo;
            cache_rem    <= div_res;
        end
    end

endmodule
